hazard_ctrl: RTL

// Pipeline hazard controller for the 5-stage RV64 core. Drives the IF/ID write-enable
// and flush, PC write-enable and ID/EX bubble insert. Resolves load-use stalls,

---
 rtl/hazard_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV64 core.
// Generates the PC / IF-ID / ID-EX steering signals for load-use stalls,
// instruction-memory waits and taken-branch redirects. It also keeps
// saturating performance counters and a sticky fetch-timeout flag that
// parks the front end in HALT until the next reset.
module hazard_ctrl #(
   parameter int unsigned REDIRECT_BUBBLES = 1,   // extra flush cycles after a redirect (0..15)
   parameter int unsigned TIMEOUT          = 255, // consecutive imem_ready=0 cycles before HALT (>=1)
   parameter int unsigned CNT_W            = 32   // width of each perf counter
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_rd,
   input  logic [4:0]       IFID_rs1,
   input  logic [4:0]       IFID_rs2,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             perf_clr,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] wait_cnt,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic             imem_timeout
);

   // The timeout counter only ever needs to reach TIMEOUT-1; the cycle that
   // would take it to TIMEOUT is the one that moves the FSM to HALT.
   localparam int unsigned   TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [3:0]    BUB_INIT = 4'(REDIRECT_BUBBLES);
   localparam bit            HAS_BUB  = (REDIRECT_BUBBLES != 0);

   // Counter slots inside the generate loop below.
   localparam int unsigned   CNT_STALL = 0;
   localparam int unsigned   CNT_WAIT  = 1;
   localparam int unsigned   CNT_REDIR = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       bub_q, bub_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             timeout_q, timeout_d;

   logic             load_use;
   logic             pc_write, ifid_write, ifid_flush, idex_flush;
   logic [2:0]       cnt_inc;

   assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                     ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

   // Zero-latency control decode plus next-state / counter-increment logic.
   always_comb begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      state_d    = state_q;
      bub_d      = bub_q;
      tmo_d      = tmo_q;
      timeout_d  = timeout_q;
      cnt_inc    = 3'b000;

      case (state_q)
         ST_RUN, ST_WAIT: begin
            if (branch_taken) begin
               // Redirect: the branch beats any stall or fetch wait this cycle.
               pc_write            = 1'b1;
               ifid_write          = 1'b1;
               ifid_flush          = 1'b1;
               idex_flush          = 1'b1;
               cnt_inc[CNT_REDIR]  = 1'b1;
               if (HAS_BUB) begin
                  state_d = ST_FLUSH;
                  bub_d   = BUB_INIT;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               if (load_use && !imem_ready) begin
                  // Hold IF/ID and the PC; the instruction in ID retries.
                  idex_flush          = 1'b1;
                  cnt_inc[CNT_STALL]  = 1'b1;
                  cnt_inc[CNT_WAIT]   = 1'b1;
               end else if (load_use) begin
                  idex_flush          = 1'b1;
                  cnt_inc[CNT_STALL]  = 1'b1;
               end else if (!imem_ready) begin
                  // No word yet: feed a NOP forward and refetch the same PC.
                  ifid_write          = 1'b1;
                  ifid_flush          = 1'b1;
                  cnt_inc[CNT_WAIT]   = 1'b1;
               end else begin
                  pc_write            = 1'b1;
                  ifid_write          = 1'b1;
               end
               state_d = imem_ready ? ST_RUN : ST_WAIT;
            end

            // Consecutive-miss tracking; reaching the limit parks the core
            // even if a redirect happened in the same cycle.
            if (imem_ready) begin
               tmo_d = '0;
            end else if (tmo_q >= TMO_LAST) begin
               state_d   = ST_HALT;
               timeout_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_FLUSH: begin
            // Post-redirect bubbles; branch and load-use inputs are ignored.
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_write   = imem_ready;
            if (imem_ready) begin
               if (bub_q <= 4'd1) begin
                  bub_d   = 4'd0;
                  state_d = ST_RUN;
               end else begin
                  bub_d = bub_q - 4'd1;
               end
            end else begin
               cnt_inc[CNT_WAIT] = 1'b1;
            end
         end

         ST_HALT: begin
            // Front end frozen; only reset leaves this state.
            idex_flush = 1'b1;
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Outputs are forced inactive while reset is held.
   assign PC_Write     = pc_write   & ~reset;
   assign IFID_Write   = ifid_write & ~reset;
   assign IFID_Flush   = ifid_flush & ~reset;
   assign IDEX_Flush   = idex_flush & ~reset;
   assign imem_timeout = timeout_q;

   // FSM state, bubble count, miss counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         bub_q     <= 4'd0;
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bub_q     <= bub_d;
         tmo_q     <= tmo_d;
         timeout_q <= timeout_d;
      end
   end

   // One saturating counter per event; a clear in the same cycle wins.
   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      // Saturating increment with synchronous clear.
      always_ff @(posedge clk) begin
         if (reset || perf_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt    = g_cnt[CNT_STALL].cnt_q;
   assign wait_cnt     = g_cnt[CNT_WAIT].cnt_q;
   assign redirect_cnt = g_cnt[CNT_REDIR].cnt_q;

endmodule
